// File: rtl/fb_pixel_sink.sv
// fb_pixel_sink: clips rasterizer pixel writes, queues them and packs 4-bit pixels into 32-bit
// SRAM words via nibble enables; includes a full-buffer clear engine. Optional macro: FB_STATS_EN.
module fb_pixel_sink #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 16
) (
    input  logic              clk,
    input  logic              areset,
    input  logic [9:0]        fb_x,
    input  logic [9:0]        fb_y,
    input  logic [3:0]        data,
    input  logic              fb_we,
    input  logic              clear_start,
    input  logic [3:0]        clear_color,
    output logic              busy,
    output logic              clear_done,
    output logic              overflow,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [7:0]        mem_nib_en,
    output logic              mem_we,
    output logic [31:0]       pix_written,
    output logic [31:0]       pix_clipped
);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int N_WORDS = WIDTH * HEIGHT / 8;
    localparam int P_W     = ADDR_W + 3;

    localparam logic [10:0]       WIDTH_C   = 11'(WIDTH);
    localparam logic [10:0]       HEIGHT_C  = 11'(HEIGHT);
    localparam logic [P_W-1:0]    WIDTH_P   = P_W'(WIDTH);
    localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [PTR_W:0]    DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W + 1)'(1);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_CLEAR = 1'b1
    } state_t;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic [3:0] c;
    } pix_t;

    pix_t fifo_mem [FIFO_DEPTH];

    state_t            state_q, state_d;
    logic [PTR_W:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]    rd_ptr_q, rd_ptr_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic [3:0]        clr_color_q, clr_color_d;
    logic              busy_q, busy_d;
    logic              done_pend_q, done_pend_d;
    logic              clear_done_q, clear_done_d;
    logic              overflow_q, overflow_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [7:0]        mem_nib_en_q, mem_nib_en_d;

    logic [PTR_W:0]    fill;
    logic              fifo_empty;
    logic              fifo_full;
    logic              in_bounds;
    logic              pop;
    logic              push;
    pix_t              head;
    logic [P_W-1:0]    p;
    logic [31:0]       pix_fill;
    logic [31:0]       clr_fill;

    assign fill       = wr_ptr_q - rd_ptr_q;
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == DEPTH_C);
    assign in_bounds  = fb_we && ({1'b0, fb_x} < WIDTH_C) && ({1'b0, fb_y} < HEIGHT_C);
    // Pops only in IDLE, so a full FIFO can still accept a pixel while draining.
    assign pop        = (state_q == S_IDLE) && !fifo_empty;
    assign push       = in_bounds && (!fifo_full || pop);
    assign head       = fifo_mem[rd_ptr_q[PTR_W-1:0]];
    assign p          = P_W'(head.y) * WIDTH_P + P_W'(head.x);

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_fill
            assign pix_fill[4*gi +: 4] = head.c;
            assign clr_fill[4*gi +: 4] = clr_color_q;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q[PTR_W-1:0]] <= {fb_x, fb_y, data};
        end
    end

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        clr_addr_d   = clr_addr_q;
        clr_color_d  = clr_color_q;
        busy_d       = busy_q;
        done_pend_d  = 1'b0;
        clear_done_d = 1'b0;
        overflow_d   = overflow_q || (in_bounds && !push);
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_nib_en_d = mem_nib_en_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end

        // Done pulse trails the last clear word by one cycle; busy drops with it.
        if (done_pend_q) begin
            clear_done_d = 1'b1;
            busy_d       = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (clear_start) begin
                    state_d     = S_CLEAR;
                    clr_addr_d  = '0;
                    clr_color_d = clear_color;
                    busy_d      = 1'b1;
                end
                if (pop) begin
                    rd_ptr_d     = rd_ptr_q + PTR_ONE;
                    mem_we_d     = 1'b1;
                    mem_addr_d   = p[ADDR_W+2:3];
                    mem_wdata_d  = pix_fill;
                    mem_nib_en_d = 8'd1 << p[2:0];
                end
            end
            S_CLEAR: begin
                mem_we_d     = 1'b1;
                mem_addr_d   = clr_addr_q;
                mem_wdata_d  = clr_fill;
                mem_nib_en_d = 8'hFF;
                clr_addr_d   = clr_addr_q + ADDR_ONE;
                if (clr_addr_q == LAST_WORD) begin
                    state_d     = S_IDLE;
                    done_pend_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            clr_addr_q   <= '0;
            clr_color_q  <= '0;
            busy_q       <= 1'b0;
            done_pend_q  <= 1'b0;
            clear_done_q <= 1'b0;
            overflow_q   <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_nib_en_q <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            clr_addr_q   <= clr_addr_d;
            clr_color_q  <= clr_color_d;
            busy_q       <= busy_d;
            done_pend_q  <= done_pend_d;
            clear_done_q <= clear_done_d;
            overflow_q   <= overflow_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_nib_en_q <= mem_nib_en_d;
        end
    end

    assign busy       = busy_q;
    assign clear_done = clear_done_q;
    assign overflow   = overflow_q;
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign mem_nib_en = mem_nib_en_q;

`ifdef FB_STATS_EN
    logic        clipped;
    logic [31:0] pix_written_q, pix_written_d;
    logic [31:0] pix_clipped_q, pix_clipped_d;

    assign clipped = fb_we && !in_bounds;

    always_comb begin
        pix_written_d = pix_written_q + {31'd0, pop};
        pix_clipped_d = pix_clipped_q + {31'd0, clipped};
    end

    always_ff @(posedge clk) begin
        if (areset) begin
            pix_written_q <= '0;
            pix_clipped_q <= '0;
        end else begin
            pix_written_q <= pix_written_d;
            pix_clipped_q <= pix_clipped_d;
        end
    end

    assign pix_written = pix_written_q;
    assign pix_clipped = pix_clipped_q;
`else
    assign pix_written = '0;
    assign pix_clipped = '0;
`endif

endmodule

// File: tb/tb_fb_pixel_sink.sv
// Self-checking bench for fb_pixel_sink: table-driven pixel vectors plus clear/overflow/reset sequences.
module tb_fb_pixel_sink;
    logic        clk = 1'b0;
    logic        areset;
    logic [9:0]  fb_x;
    logic [9:0]  fb_y;
    logic [3:0]  data;
    logic        fb_we;
    logic        clear_start;
    logic [3:0]  clear_color;
    logic        busy;
    logic        clear_done;
    logic        overflow;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_nib_en;
    logic        mem_we;
    logic [31:0] pix_written;
    logic [31:0] pix_clipped;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fb_pixel_sink dut (
        .clk        (clk),
        .areset     (areset),
        .fb_x       (fb_x),
        .fb_y       (fb_y),
        .data       (data),
        .fb_we      (fb_we),
        .clear_start(clear_start),
        .clear_color(clear_color),
        .busy       (busy),
        .clear_done (clear_done),
        .overflow   (overflow),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_nib_en (mem_nib_en),
        .mem_we     (mem_we),
        .pix_written(pix_written),
        .pix_clipped(pix_clipped)
    );

    typedef struct {
        logic [9:0]  x;
        logic [9:0]  y;
        logic [3:0]  d;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  nib;
    } vec_t;

    vec_t vecs [9];

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    initial begin
        int clr_cnt, clr_bad, first_clr, busy_bad, done_pulses, done_at;
        int pix_cnt, pix_bad, first_pix, found, quiet_bad;
        logic busy_at_done;
        logic [31:0] exp_wd;
        int pp;

        areset = 1'b1; fb_we = 1'b0; fb_x = '0; fb_y = '0; data = '0;
        clear_start = 1'b0; clear_color = '0;

        vecs[0] = '{10'd0,    10'd0,    4'hA, 1'b1, 16'd0,     8'h01};
        vecs[1] = '{10'd13,   10'd1,    4'h5, 1'b1, 16'd81,    8'h20};
        vecs[2] = '{10'd639,  10'd479,  4'hF, 1'b1, 16'd38399, 8'h80};
        vecs[3] = '{10'd640,  10'd0,    4'h1, 1'b0, 16'd0,     8'h00};
        vecs[4] = '{10'd0,    10'd480,  4'h2, 1'b0, 16'd0,     8'h00};
        vecs[5] = '{10'd7,    10'd0,    4'hC, 1'b1, 16'd0,     8'h80};
        vecs[6] = '{10'd8,    10'd0,    4'h3, 1'b1, 16'd1,     8'h01};
        vecs[7] = '{10'd1023, 10'd1023, 4'h9, 1'b0, 16'd0,     8'h00};
        vecs[8] = '{10'd100,  10'd2,    4'h6, 1'b1, 16'd172,   8'h10};

        repeat (3) tick;
        chk("rst_busy", busy, 0);
        chk("rst_clear_done", clear_done, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_nib_en", mem_nib_en, 0);
        chk("rst_pix_written", pix_written, 0);
        areset = 1'b0;
        tick;

        // Single pixels: no write one cycle later, registered write two cycles later.
        for (int i = 0; i < 9; i++) begin
            fb_x = vecs[i].x; fb_y = vecs[i].y; data = vecs[i].d; fb_we = 1'b1;
            tick;
            fb_we = 1'b0;
            chk($sformatf("vec%0d_we_n1", i), mem_we, 0);
            tick;
            chk($sformatf("vec%0d_we", i), mem_we, vecs[i].we);
            if (vecs[i].we) begin
                chk($sformatf("vec%0d_addr", i), mem_addr, vecs[i].addr);
                chk($sformatf("vec%0d_nib", i), mem_nib_en, vecs[i].nib);
                chk($sformatf("vec%0d_wdata", i), mem_wdata, {8{vecs[i].d}});
            end
        end
        chk("clip_no_overflow", overflow, 0);
`ifdef FB_STATS_EN
        chk("stats_written_a", pix_written, 6);
        chk("stats_clipped_a", pix_clipped, 3);
`else
        chk("stats_written_a", pix_written, 0);
        chk("stats_clipped_a", pix_clipped, 0);
`endif

        // Full clear with 20 pixels streamed from the clear_start cycle; second start ignored.
        clr_cnt = 0; clr_bad = 0; first_clr = -1; busy_bad = 0; done_pulses = 0; done_at = -1;
        pix_cnt = 0; pix_bad = 0; first_pix = -1; busy_at_done = 1'b1;
        clear_start = 1'b1; clear_color = 4'h3;
        fb_we = 1'b1; fb_x = 10'd10; fb_y = 10'd5; data = 4'h0;
        for (int s = 1; s <= 38430; s++) begin
            tick;
            if (mem_we) begin
                if (clr_cnt < 38400) begin
                    if (mem_addr !== 16'(clr_cnt) || mem_wdata !== 32'h33333333 || mem_nib_en !== 8'hFF)
                        clr_bad++;
                    if (first_clr < 0) first_clr = s;
                    clr_cnt++;
                end else begin
                    pp = 3210 + pix_cnt;
                    exp_wd = {8{pix_cnt[3:0]}};
                    if (pix_cnt >= 16 || mem_addr !== 16'(pp / 8) ||
                        mem_nib_en !== (8'd1 << (pp % 8)) || mem_wdata !== exp_wd)
                        pix_bad++;
                    if (first_pix < 0) first_pix = s;
                    pix_cnt++;
                end
            end
            if (s <= 38401 && busy !== 1'b1) busy_bad++;
            if (clear_done) begin
                done_pulses++;
                if (done_at < 0) begin
                    done_at = s;
                    busy_at_done = busy;
                end
            end
            clear_start = (s == 50);
            clear_color = (s == 50) ? 4'h7 : 4'h3;
            if (s < 20) begin
                fb_we = 1'b1; fb_x = 10'(10 + s); data = s[3:0];
            end else begin
                fb_we = 1'b0;
            end
        end
        chk("clr_words", clr_cnt, 38400);
        chk("clr_bad_words", clr_bad, 0);
        chk("clr_first_cycle", first_clr, 2);
        chk("clr_busy_bad", busy_bad, 0);
        chk("clr_done_pulses", done_pulses, 1);
        chk("clr_done_cycle", done_at, 38402);
        chk("clr_busy_at_done", busy_at_done, 0);
        chk("fifo_pix_count", pix_cnt, 16);
        chk("fifo_pix_bad", pix_bad, 0);
        chk("fifo_first_pix", first_pix, 38402);
        chk("fifo_overflow", overflow, 1);
`ifdef FB_STATS_EN
        chk("stats_written_b", pix_written, 22);
        chk("stats_clipped_b", pix_clipped, 3);
`else
        chk("stats_written_b", pix_written, 0);
        chk("stats_clipped_b", pix_clipped, 0);
`endif

        // Reset at clear word 100 with a queued pixel; then a fresh clear starts at 0.
        found = 0;
        clear_start = 1'b1; clear_color = 4'h9;
        fb_we = 1'b1; fb_x = 10'd1; fb_y = 10'd0; data = 4'h4;
        for (int s = 0; s < 300; s++) begin
            tick;
            clear_start = 1'b0; fb_we = 1'b0;
            if (mem_we && mem_addr == 16'd100) begin
                found = 1;
                break;
            end
        end
        chk("t6_reach_word100", found, 1);
        areset = 1'b1;
        tick;
        chk("t6_busy", busy, 0);
        chk("t6_clear_done", clear_done, 0);
        chk("t6_overflow", overflow, 0);
        chk("t6_mem_we", mem_we, 0);
        chk("t6_mem_addr", mem_addr, 0);
        chk("t6_mem_wdata", mem_wdata, 0);
        chk("t6_nib_en", mem_nib_en, 0);
        chk("t6_pix_written", pix_written, 0);
        chk("t6_pix_clipped", pix_clipped, 0);
        areset = 1'b0;
        quiet_bad = 0;
        repeat (40) begin
            tick;
            if (mem_we || clear_done || busy) quiet_bad++;
        end
        chk("t6_quiet_after_reset", quiet_bad, 0);
        clear_start = 1'b1; clear_color = 4'h2;
        tick;
        clear_start = 1'b0;
        chk("t6_new_busy", busy, 1);
        tick;
        chk("t6_new_we", mem_we, 1);
        chk("t6_new_addr0", mem_addr, 0);
        chk("t6_new_wdata", mem_wdata, 32'h22222222);
        chk("t6_new_nib", mem_nib_en, 8'hFF);
        tick;
        chk("t6_new_addr1", mem_addr, 1);
        areset = 1'b1;
        tick;
        areset = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
